// File: rtl/updown_ctrl.sv
// updown_ctrl: debounced direction and run/pause buttons for the lab counter.
// Produces the count direction, run state and a rate-divided count-enable tick.
module updown_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TICK_DIV        = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_dir,
    input  logic btn_run,
    output logic updown,
    output logic run,
    output logic tick,
    output logic dir_pulse
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

    typedef enum logic {
        STOP = 1'b0,
        RUN  = 1'b1
    } run_t;

    // bit 0 = direction button, bit 1 = run button
    logic [1:0]         btn;
    logic [1:0]         s1;
    logic [1:0]         s2;
    logic [1:0]         db;
    logic [1:0]         db_q;
    logic [1:0][DW-1:0] dcnt;
    logic [1:0]         rise;
    logic               dir_edge;
    logic               run_edge;
    logic [PW-1:0]      pcnt;
    run_t               state_q;
    run_t               state_d;

    assign btn      = {btn_run, btn_dir};
    assign rise     = db & ~db_q;
    assign dir_edge = rise[0];
    assign run_edge = rise[1];
    assign run      = (state_q == RUN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1   <= '0;
            s2   <= '0;
            db   <= '0;
            db_q <= '0;
            dcnt <= '0;
        end else begin
            s1   <= btn;
            s2   <= s1;
            db_q <= db;
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == db[i]) begin
                    dcnt[i] <= '0;
                end else if (dcnt[i] == DMAX) begin
                    db[i]   <= s2[i];
                    dcnt[i] <= '0;
                end else begin
                    dcnt[i] <= dcnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= STOP;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            STOP: if (run_edge) state_d = RUN;
            RUN:  if (run_edge) state_d = STOP;
            default: state_d = STOP;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            updown    <= 1'b1;
            dir_pulse <= 1'b0;
        end else begin
            updown    <= updown ^ dir_edge;
            dir_pulse <= dir_edge;
        end
    end

    // A direction change restarts the period so the counter never steps
    // in the same cycle its direction flips.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcnt <= '0;
            tick <= 1'b0;
        end else if (!run || dir_edge) begin
            pcnt <= '0;
            tick <= 1'b0;
        end else if (pcnt == PMAX) begin
            pcnt <= '0;
            tick <= 1'b1;
        end else begin
            pcnt <= pcnt + 1'b1;
            tick <= 1'b0;
        end
    end

endmodule

// File: doc/updown_ctrl.md
# updown_ctrl

Front-end control stage for the lab up/down counter. It debounces two raw push-buttons: a direction button and a run/pause button. From them it produces the counter's `updown` level and a one-cycle count-enable `tick` at a programmable rate. Its outputs drive the counter's `updown` input and its count-enable directly, and the counter feeds the 7-segment display.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronized samples required before a button change is accepted; legal range ≥1.
- `TICK_DIV`, default 8: `tick` period in clock cycles while running; legal range ≥2.

Ports:
- `clk`  in  1: single system clock; all state changes on rising edge.
- `rst`  in  1: reset. Reset is asynchronous and active-low; all state is cleared while `rst`=0.
- `btn_dir`  in  1: raw direction button, asynchronous, active-high, may bounce.
- `btn_run`  in  1: raw run/pause button, asynchronous, active-high, may bounce.
- `updown`  out  1: count direction, 1=up, 0=down; registered.
- `run`  out  1: 1 = counting enabled; registered.
- `tick`  out  1: one-cycle count enable; registered.
- `dir_pulse`  out  1: one-cycle strobe on each accepted direction change; registered.

## Operation

- **Reset values** (while `rst`=0):
  - `updown`=1, `run`=0, `tick`=0, `dir_pulse`=0.
  - Synchronizers, debounced states and all counters = 0.
- **Synchronizer:** each button passes through a two-flop synchronizer (s1→s2).
- **Debounce,** per button: debounced state `db`, counter `dcnt` of width clog2(DEBOUNCE_CYCLES)+1.
  - s2==`db`: `dcnt`<=0.
  - s2!=`db` and `dcnt`==DEBOUNCE_CYCLES-1: `db`<=s2, `dcnt`<=0.
  - Otherwise: `dcnt`<=`dcnt`+1.
  - Any s2 excursion shorter than DEBOUNCE_CYCLES cycles leaves `db` unchanged.
- **Edge detect:** a rising edge of debounced `db_dir` toggles `updown` and asserts `dir_pulse` for exactly one cycle. A rising edge of `db_run` toggles `run`. Falling edges are ignored.
- **Prescaler:** `pcnt`, width clog2(TICK_DIV). Evaluated each edge in this priority:
  1. `run`=0, or a dir edge detected this cycle: `pcnt`<=0, `tick`<=0.
  2. `pcnt`==TICK_DIV-1: `pcnt`<=0, `tick`<=1.
  3. Otherwise: `pcnt`<=`pcnt`+1, `tick`<=0.
- **No state machine beyond the above;** `run` is a two-state toggle, STOP(0) ↔ RUN(1).

## Timing

- **Button latency:** raw button rises, first sampled at edge E0.
  - s2 high after E1.
  - `db` high after E1+DEBOUNCE_CYCLES.
  - `updown`/`run` toggle and `dir_pulse` rise after edge E2+DEBOUNCE_CYCLES. With defaults this is 6 edges after E0.
- **`dir_pulse`:** high for exactly one cycle per accepted press, regardless of how long the button is held.
- **Tick timing:** with `run` going to 1 after edge R, the first `tick` is high after edge R+TICK_DIV. Subsequent ticks recur every TICK_DIV cycles, each one cycle wide.
- **Run to 0:** `tick` is 0 from the next edge onward. No partial tick. `pcnt` is cleared, so a resume starts a full period.
- **Simultaneous events:**
  - A direction toggle in the same cycle the prescaler would wrap suppresses that tick and restarts the period. The counter therefore never steps in the cycle its direction changes.
  - Simultaneous accepted dir and run edges are both applied on the same edge.
- **Reset mid-operation:** asserting `rst` low at any time forces all outputs to their reset values immediately (asynchronously). Release is synchronous to the next `clk` edge. A button held through reset is accepted as a new press after release plus the normal latency, since `db` resets to 0.

## Test plan

- **Reset:** `rst`=0 for 50 ns, then release → `updown`=1, `run`=0, `tick`=0, `dir_pulse`=0 throughout reset and until the first button press.
- **Clean direction press:** clean `btn_dir` high for 20 cycles (defaults) → `updown` 1→0 exactly 6 edges after first sample; `dir_pulse` high 1 cycle; release produces no change.
- **Bounce rejection:** `btn_dir` bouncing with 1–3-cycle pulses for 30 cycles, then stable high → exactly one `updown` toggle and one `dir_pulse`.
- **Run and pause:**
  - Press `btn_run` with TICK_DIV=8 → `run`=1, then `tick` pulses every 8 cycles, first 8 edges after `run` rises.
  - Press again → `run`=0, no further ticks.
- **Collision:** with `run`=1, time a `btn_dir` press so its accepted edge lands on `pcnt`==7 → no `tick` that cycle; next `tick` 8 cycles later.
- **Mid-operation reset:** drop `rst` while running with `updown`=0 → outputs return to reset values within the same cycle; `tick` stays 0 until `btn_run` is pressed again.
